// File: rtl/button_conditioner_if.sv
// Bundle of raw button inputs and conditioned outputs shared between the
// button conditioner (slave) and whatever drives/consumes it (master).
interface button_conditioner_if #(
  parameter int N_BTN = 5
);
  logic [N_BTN-1:0] btn_in;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_pulse;
  logic [N_BTN-1:0] btn_repeat;
  logic             any_pressed;

  modport master (
    output btn_in,
    input  btn_level, btn_pulse, btn_repeat, any_pressed
  );

  modport slave (
    input  btn_in,
    output btn_level, btn_pulse, btn_repeat, any_pressed
  );
endinterface

// File: rtl/button_conditioner.sv
// Per-button synchronizer, debouncer, press pulse and hold-to-repeat generator.
// Channels are fully independent; only any_pressed combines them.
module button_conditioner #(
  parameter int N_BTN         = 5,
  parameter int DEB_CYCLES    = 1000000,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input logic                clk,
  input logic                rst,
  button_conditioner_if.slave btn
);
  localparam int DEB_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

  localparam logic [DEB_W-1:0]  DEB_LAST    = DEB_W'(DEB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ARMING    = 2'd1;
  localparam logic [1:0] REPEATING = 2'd2;

  logic [N_BTN-1:0] level_nxt;
  logic             any_q;

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    logic              s1;
    logic              s2;
    logic              level;
    logic              pulse;
    logic              rpt;
    logic              accept;
    logic [DEB_W-1:0]  deb_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [1:0]        state;

    // The counter only runs while s2 disagrees, so reaching DEB_LAST means the
    // new level has been stable for DEB_CYCLES consecutive samples.
    assign accept       = (s2 != level) && (deb_cnt == DEB_LAST);
    assign level_nxt[i] = accept ? ~level : level;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        s1      <= 1'b0;
        s2      <= 1'b0;
        deb_cnt <= '0;
        level   <= 1'b0;
        pulse   <= 1'b0;
      end else begin
        s1 <= btn.btn_in[i];
        s2 <= s1;
        if ((s2 == level) || accept) deb_cnt <= '0;
        else                         deb_cnt <= deb_cnt + 1'b1;
        level <= level_nxt[i];
        pulse <= accept && !level;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state    <= IDLE;
        hold_cnt <= '0;
        rpt      <= 1'b0;
      end else begin
        rpt <= 1'b0;
        if (accept && level) begin
          state    <= IDLE;
          hold_cnt <= '0;
        end else if (accept) begin
          state    <= ARMING;
          hold_cnt <= '0;
          rpt      <= 1'b1;
        end else begin
          case (state)
            // A zero delay parks the channel here so only the press pulse repeats.
            ARMING: begin
              if (REPEAT_DELAY != 0) begin
                if (hold_cnt == DELAY_LAST) begin
                  rpt      <= 1'b1;
                  hold_cnt <= '0;
                  state    <= REPEATING;
                end else begin
                  hold_cnt <= hold_cnt + 1'b1;
                end
              end
            end
            REPEATING: begin
              if (hold_cnt == PERIOD_LAST) begin
                rpt      <= 1'b1;
                hold_cnt <= '0;
              end else begin
                hold_cnt <= hold_cnt + 1'b1;
              end
            end
            default: begin
              state    <= IDLE;
              hold_cnt <= '0;
            end
          endcase
        end
      end
    end

    assign btn.btn_level[i]  = level;
    assign btn.btn_pulse[i]  = pulse;
    assign btn.btn_repeat[i] = rpt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) any_q <= 1'b0;
    else      any_q <= |level_nxt;
  end

  assign btn.any_pressed = any_q;
endmodule

// File: tb/tb_button_conditioner.sv
// Directed and randomized checks of button_conditioner against a cycle-level
// model built from the debounce-run-length and press-age rules.
module tb_button_conditioner;
  localparam int N     = 5;
  localparam int DEB   = 4;
  localparam int DELAY = 10;
  localparam int PER   = 5;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  button_conditioner_if #(.N_BTN(N)) bus ();

  button_conditioner #(
    .N_BTN(N), .DEB_CYCLES(DEB), .REPEAT_DELAY(DELAY), .REPEAT_PERIOD(PER)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: a level flips once the synchronized input has disagreed for DEB
  // straight samples; repeats fire at press age 0, DELAY, DELAY+PER, ...
  logic [N-1:0] m_s1, m_s2, m_level, m_pulse, m_rpt;
  int           m_run [N];
  int           m_age [N];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_s1    <= '0;
      m_s2    <= '0;
      m_level <= '0;
      m_pulse <= '0;
      m_rpt   <= '0;
      for (int i = 0; i < N; i++) begin
        m_run[i] <= 0;
        m_age[i] <= 0;
      end
    end else begin
      logic [N-1:0] lvl, pul, rp;
      int           run [N];
      int           age [N];
      logic         rose;
      lvl = m_level;
      run = m_run;
      age = m_age;
      for (int i = 0; i < N; i++) begin
        rose = 1'b0;
        if (m_s2[i] != lvl[i]) begin
          run[i] = run[i] + 1;
          if (run[i] == DEB) begin
            run[i] = 0;
            rose   = !lvl[i];
            lvl[i] = !lvl[i];
          end
        end else begin
          run[i] = 0;
        end
        if (rose)        age[i] = 0;
        else if (lvl[i]) age[i] = age[i] + 1;
        pul[i] = rose;
        rp[i]  = lvl[i] && (rose || (DELAY > 0 && age[i] >= DELAY && ((age[i] - DELAY) % PER) == 0));
      end
      m_level <= lvl;
      m_pulse <= pul;
      m_rpt   <= rp;
      m_run   <= run;
      m_age   <= age;
      m_s2    <= m_s1;
      m_s1    <= bus.btn_in;
    end
  end

  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, "_level"},  64'(bus.btn_level),   64'(m_level));
    checkValue({tag, "_pulse"},  64'(bus.btn_pulse),   64'(m_pulse));
    checkValue({tag, "_repeat"}, 64'(bus.btn_repeat),  64'(m_rpt));
    checkValue({tag, "_any"},    64'(bus.any_pressed), 64'(|m_level));
  endtask

  // Called at a falling edge: drive, let one rising edge pass, check at the next falling edge.
  task automatic applyStimulus(input logic [N-1:0] pattern, input int cycles, input string tag);
    for (int c = 0; c < cycles; c++) begin
      bus.btn_in = pattern;
      @(posedge clk);
      @(negedge clk);
      checkOutput(tag);
    end
  endtask

  initial begin
    int               edges;
    int               pulses;
    logic [N-1:0]     act;
    logic [N-1:0]     rnd;
    logic [39:0]      rpt_seen;
    logic [39:0]      pul_seen;
    logic [39:0]      rpt_exp;

    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    bus.btn_in  = 5'h1F;

    // Held in reset with every button down: everything stays cleared.
    @(negedge clk);
    applyStimulus(5'h1F, 3, "in_reset");
    checkValue("reset_level", 64'(bus.btn_level), 64'(0));
    checkValue("reset_any",   64'(bus.any_pressed), 64'(0));

    // Release with buttons still held: level rises on the 6th edge.
    rst   = 1'b1;
    edges = 0;
    while (bus.btn_level !== 5'h1F && edges < 20) begin
      applyStimulus(5'h1F, 1, "held_release");
      edges++;
    end
    checkValue("held_release_edges", 64'(edges), 64'(6));
    checkValue("held_release_pulse",  64'(bus.btn_pulse),  64'(5'h1F));
    checkValue("held_release_repeat", 64'(bus.btn_repeat), 64'(5'h1F));
    checkValue("held_release_any",    64'(bus.any_pressed), 64'(1));
    applyStimulus(5'h1F, 1, "held_after");
    checkValue("held_after_pulse", 64'(bus.btn_pulse), 64'(0));
    applyStimulus(5'h1F, 8, "held_hold");
    applyStimulus(5'h00, 12, "all_release");

    // A 3-cycle glitch on BtnU must be invisible.
    act = '0;
    for (int c = 0; c < 13; c++) begin
      applyStimulus((c < 3) ? 5'h02 : 5'h00, 1, "glitch");
      act |= bus.btn_level | bus.btn_pulse | bus.btn_repeat | {4'b0, bus.any_pressed};
    end
    checkValue("glitch_activity", 64'(act), 64'(0));

    // Bounce on BtnL, then stable high: rise 6 edges after the final transition.
    pulses = 0;
    applyStimulus(5'h08, 2, "bounce");
    pulses += int'(bus.btn_pulse[3]);
    applyStimulus(5'h00, 1, "bounce");
    pulses += int'(bus.btn_pulse[3]);
    edges = 0;
    while (bus.btn_level[3] !== 1'b1 && edges < 20) begin
      applyStimulus(5'h08, 1, "bounce_settle");
      pulses += int'(bus.btn_pulse[3]);
      edges++;
    end
    checkValue("bounce_edges", 64'(edges), 64'(6));
    for (int c = 0; c < 5; c++) begin
      applyStimulus(5'h08, 1, "bounce_hold");
      pulses += int'(bus.btn_pulse[3]);
    end
    checkValue("bounce_pulse_count", 64'(pulses), 64'(1));
    applyStimulus(5'h00, 12, "bounce_release");

    // Hold BtnR and record repeat offsets relative to the level rise.
    edges = 0;
    while (bus.btn_level[2] !== 1'b1 && edges < 20) begin
      applyStimulus(5'h04, 1, "repeat_press");
      edges++;
    end
    checkValue("repeat_press_edges", 64'(edges), 64'(6));
    rpt_seen = '0;
    pul_seen = '0;
    for (int off = 0; off < 40; off++) begin
      if (off > 0) applyStimulus(5'h04, 1, "repeat_hold");
      rpt_seen[off] = bus.btn_repeat[2];
      pul_seen[off] = bus.btn_pulse[2];
    end
    rpt_exp = '0;
    rpt_exp[0]  = 1'b1;
    rpt_exp[10] = 1'b1;
    rpt_exp[15] = 1'b1;
    rpt_exp[20] = 1'b1;
    rpt_exp[25] = 1'b1;
    rpt_exp[30] = 1'b1;
    rpt_exp[35] = 1'b1;
    checkValue("repeat_offsets", 64'(rpt_seen), 64'(rpt_exp));
    checkValue("repeat_pulse_offsets", 64'(pul_seen), 64'(40'h1));

    // Release mid-repeat: the fall lands where a repeat would have fired.
    edges = 0;
    while (bus.btn_level[2] !== 1'b0 && edges < 20) begin
      applyStimulus(5'h00, 1, "repeat_release");
      edges++;
    end
    checkValue("repeat_release_edges", 64'(edges), 64'(6));
    checkValue("repeat_release_repeat", 64'(bus.btn_repeat), 64'(0));
    checkValue("repeat_release_pulse",  64'(bus.btn_pulse),  64'(0));
    checkValue("repeat_release_any",    64'(bus.any_pressed), 64'(0));
    applyStimulus(5'h00, 4, "repeat_idle");

    // Random slow-bouncing buttons against the model.
    rnd = '0;
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 5) == 0) rnd[b] = ~rnd[b];
      applyStimulus(rnd, 1, "random");
    end
    applyStimulus(5'h00, 12, "random_release");

    // Simultaneous BtnC + BtnD, then asynchronous reset during repeating.
    edges = 0;
    while (bus.btn_level !== 5'h11 && edges < 20) begin
      applyStimulus(5'h11, 1, "dual_press");
      edges++;
    end
    checkValue("dual_edges",  64'(edges), 64'(6));
    checkValue("dual_pulse",  64'(bus.btn_pulse),  64'(5'h11));
    checkValue("dual_repeat", 64'(bus.btn_repeat), 64'(5'h11));
    applyStimulus(5'h11, 13, "dual_hold");
    #2 rst = 1'b0;
    #1;
    checkValue("async_level",  64'(bus.btn_level),   64'(0));
    checkValue("async_pulse",  64'(bus.btn_pulse),   64'(0));
    checkValue("async_repeat", 64'(bus.btn_repeat),  64'(0));
    checkValue("async_any",    64'(bus.any_pressed), 64'(0));
    @(negedge clk);
    applyStimulus(5'h11, 2, "async_hold");
    rst = 1'b1;
    applyStimulus(5'h11, 1, "async_release");
    checkValue("async_release_pulse", 64'(bus.btn_pulse), 64'(0));
    applyStimulus(5'h11, 10, "async_repress");
    applyStimulus(5'h00, 8, "final_release");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter N_BTN, default 5: number of independent button channels; bit map [0]=BtnC, [1]=BtnU, [2]=BtnR, [3]=BtnL, [4]=BtnD.
REQ-002 Parameter DEB_CYCLES, default 1000000: consecutive stable cycles required to accept a level change (10 ms at 100 MHz); legal range >= 1.
REQ-003 Parameter REPEAT_DELAY, default 50000000: held cycles from press acceptance to first auto-repeat pulse (500 ms); value 0 disables auto-repeat.
REQ-004 Parameter REPEAT_PERIOD, default 10000000: cycles between later auto-repeat pulses (100 ms); legal range >= 1.
REQ-005 clk  input  1  system clock (ClkPort domain, 100 MHz).
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 btn_in  input  N_BTN  raw, asynchronous, bouncing button levels (1 = pressed).
REQ-008 btn_level  output  N_BTN  debounced button level, registered.
REQ-009 btn_pulse  output  N_BTN  single-cycle pulse on accepted press, registered.
REQ-010 btn_repeat  output  N_BTN  press pulse plus auto-repeat pulses while held; drives the block_controller up/down/left/right inputs.
REQ-011 any_pressed  output  1  OR of btn_level, registered.

Function
REQ-012 Each channel SHALL pass btn_in through a two-flop synchronizer (s1, s2) before any other logic.
REQ-013 Each channel SHALL have a debounce counter that increments every cycle s2 != btn_level, clears every cycle s2 == btn_level, and never wraps.
REQ-014 When s2 != btn_level and the counter equals DEB_CYCLES-1, btn_level SHALL toggle on that edge and the counter SHALL clear.
REQ-015 Latency: a raw change held stable SHALL appear on btn_level on the (DEB_CYCLES+2)th rising edge counting the first sampling edge.
REQ-016 A bounce (s2 returning to btn_level before the count completes) SHALL restart the count from 0; pulses shorter than DEB_CYCLES cycles after synchronization SHALL produce no output change.
REQ-017 btn_pulse[i] SHALL be 1 for exactly the cycle in which btn_level[i] first reads 1; a release SHALL produce no pulse.
REQ-018 Each channel SHALL run a repeat FSM with states IDLE, ARMING, REPEATING and a hold counter, width sized for max(REPEAT_DELAY, REPEAT_PERIOD).
REQ-019 IDLE -> ARMING on accepted press; btn_repeat pulses in the same cycle as btn_pulse; hold counter cleared.
REQ-020 ARMING: hold counter increments each cycle; when the count reaches REPEAT_DELAY, btn_repeat pulses one cycle, counter clears, next state REPEATING.
REQ-021 REPEATING: when the hold counter reaches REPEAT_PERIOD, btn_repeat pulses one cycle and the counter clears; the FSM stays in REPEATING.
REQ-022 Any state -> IDLE in the cycle btn_level falls; the hold counter clears; no pulse on that cycle.
REQ-023 With REPEAT_DELAY = 0, the FSM SHALL stay in ARMING without counting; btn_repeat then equals btn_pulse.
REQ-024 Channels SHALL be fully independent; simultaneous presses SHALL produce pulses in the same cycle on every affected bit.
REQ-025 any_pressed SHALL update in the same cycle as the btn_level change that causes it.

Reset
REQ-026 rst = 0 SHALL immediately, without a clock edge, clear s1, s2, all counters, all FSMs (IDLE) and all outputs to 0.
REQ-027 A button held through reset release SHALL be treated as a new press: level rises per REQ-015 with one btn_pulse and btn_repeat.
REQ-028 Reset asserted mid-debounce or mid-repeat SHALL discard the in-progress count; no pulse SHALL be emitted in the cycle of reset release.

Verification (DEB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5)
REQ-029 Sequence: hold rst=0 with btn_in=5'h1F. Expect all outputs 0. Then release reset. Expect btn_level=5'h1F on the 6th edge, btn_pulse=btn_repeat=5'h1F for one cycle, and any_pressed=1 in the same cycle.
REQ-030 Drive btn_in[1] high for 3 cycles, then low. Expect btn_level, btn_pulse, btn_repeat and any_pressed to stay 0 throughout.
REQ-031 Drive btn_in[3] high 2 cycles, low 1 cycle, high stable. Expect btn_level[3] to rise 6 edges after the final rising transition, with exactly one btn_pulse[3].
REQ-032 Hold btn_in[2] for 40 cycles after btn_level[2] rises. Expect btn_repeat[2] pulses at offsets 0, 10, 15, 20, 25, 30, 35 and btn_pulse[2] only at offset 0.
REQ-033 Release btn_in[2] mid-REPEATING. Expect btn_level[2] and any_pressed to fall after 6 edges, with no pulse on either pulse output and the FSM in IDLE.
REQ-034 Press bits 0 and 4 in the same cycle, then drive rst=0 asynchronously during REPEATING. Expect simultaneous pulses on both bits, then all outputs 0 before the next clk edge.
